button_event_arbiter: RTL and testbench



---
 rtl/button_event_arbiter_if.sv | 24 ++
 rtl/button_event_arbiter.sv | 146 ++++++++++++++
 tb/tb_button_event_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_if.sv
// Button event channel: raw pulses in, one serialised event stream out,
// plus per-button status.
interface button_event_arbiter_if #(
  parameter int N_BTN = 4,
  parameter int IDW   = 2
);
  logic [N_BTN-1:0] btn_pulse;
  logic             evt_valid;
  logic [IDW-1:0]   evt_id;
  logic             evt_ready;
  logic [N_BTN-1:0] pending;
  logic             overflow;
  logic             busy;

  modport master (
    input  btn_pulse, evt_ready,
    output evt_valid, evt_id, pending, overflow, busy
  );

  modport slave (
    output btn_pulse, evt_ready,
    input  evt_valid, evt_id, pending, overflow, busy
  );
endinterface

// File: rtl/button_event_arbiter.sv
// Queues debounced button pulses and serialises them round-robin onto one
// valid/ready event channel, with a per-button hold-off after each delivery.
module button_event_arbiter #(
  parameter int N_BTN   = 4,
  parameter int HOLDOFF = 16,
  parameter int IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  button_event_arbiter_if.master bus
);

  localparam int CW = IDW + 1;

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [N_BTN-1:0] pending_r;
  logic             evt_valid_r;
  logic [IDW-1:0]   evt_id_r;
  logic [IDW-1:0]   last_grant_r;
  logic             overflow_r;
  logic [7:0]       holdoff_r [N_BTN];

  logic             load_s;
  logic             handshake_s;
  logic             sel_found_s;
  logic [IDW-1:0]   sel_id_s;
  logic [CW-1:0]    cand_s;
  logic [N_BTN-1:0] sel_mask_s;
  logic [N_BTN-1:0] hit_s;
  logic [N_BTN-1:0] occupied_s;
  logic [N_BTN-1:0] accept_s;
  logic [N_BTN-1:0] drop_s;

  // Round-robin pick: first pending bit after last_grant, wrapping modulo N_BTN.
  always_comb begin
    sel_found_s = 1'b0;
    sel_id_s    = '0;
    cand_s      = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand_s = {1'b0, last_grant_r} + CW'(k);
      if (cand_s >= CW'(N_BTN)) begin
        cand_s = cand_s - CW'(N_BTN);
      end else begin
        cand_s = cand_s;
      end
      if (!sel_found_s && pending_r[cand_s[IDW-1:0]]) begin
        sel_found_s = 1'b1;
        sel_id_s    = cand_s[IDW-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = sel_found_s ? OFFER : IDLE;
      OFFER:   state_next_s = bus.evt_ready ? IDLE : OFFER;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    load_s      = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE:    load_s      = sel_found_s;
      OFFER:   handshake_s = bus.evt_ready;
      default: begin
        load_s      = 1'b0;
        handshake_s = 1'b0;
      end
    endcase
  end

  assign sel_mask_s = load_s ? (N_BTN'(1) << sel_id_s) : '0;

  // A pulse is dropped when its button is already queued, on offer, or being picked.
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    assign hit_s[g]      = bus.btn_pulse[g] && (holdoff_r[g] == 8'd0);
    assign occupied_s[g] = pending_r[g]
                         || (evt_valid_r && (evt_id_r == IDW'(g)))
                         || (load_s && (sel_id_s == IDW'(g)));

    // Hold-off counter: reloaded when this button's event is accepted.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        holdoff_r[g] <= 8'd0;
      end else if (handshake_s && (evt_id_r == IDW'(g))) begin
        holdoff_r[g] <= 8'(HOLDOFF);
      end else if (holdoff_r[g] != 8'd0) begin
        holdoff_r[g] <= holdoff_r[g] - 8'd1;
      end else begin
        holdoff_r[g] <= 8'd0;
      end
    end
  end

  assign accept_s = hit_s & ~occupied_s;
  assign drop_s   = hit_s & occupied_s;

  // Pending flags, event register, grant pointer and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r    <= '0;
      evt_valid_r  <= 1'b0;
      evt_id_r     <= '0;
      last_grant_r <= IDW'(N_BTN - 1);
      overflow_r   <= 1'b0;
    end else begin
      pending_r  <= (pending_r & ~sel_mask_s) | accept_s;
      overflow_r <= |drop_s;
      if (load_s) begin
        evt_valid_r <= 1'b1;
        evt_id_r    <= sel_id_s;
      end else if (handshake_s) begin
        evt_valid_r  <= 1'b0;
        last_grant_r <= evt_id_r;
      end else begin
        evt_valid_r <= evt_valid_r;
      end
    end
  end

  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_id    = evt_id_r;
  assign bus.pending   = pending_r;
  assign bus.overflow  = overflow_r;
  assign bus.busy      = evt_valid_r | (|pending_r);

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench: vector table for single-edge behaviour, hand sequences for
// the long stall and hold-off window.
module tb_button_event_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  button_event_arbiter_if #(.N_BTN(4), .IDW(2)) bus ();

  button_event_arbiter #(.N_BTN(4), .HOLDOFF(16), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] pulse;
    logic       ready;
    logic       ev;
    logic [1:0] id;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] p, input logic rd,
                     input logic ev, input logic [1:0] id, input logic [3:0] pend,
                     input logic ovf);
    vec_t v;
    v.rst = r; v.pulse = p; v.ready = rd;
    v.ev = ev; v.id = id; v.pend = pend; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] p, input logic rd);
    rst_n         = r;
    bus.btn_pulse = p;
    bus.evt_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [1:0] id,
                            input logic [3:0] pend, input logic ovf);
    cmp({tag, " evt_valid"}, int'(bus.evt_valid), int'(ev));
    cmp({tag, " evt_id"},    int'(bus.evt_id),    int'(id));
    cmp({tag, " pending"},   int'(bus.pending),   int'(pend));
    cmp({tag, " overflow"},  int'(bus.overflow),  int'(ovf));
    cmp({tag, " busy"},      int'(bus.busy),      int'(ev | (|pend)));
  endtask

  initial begin
    bus.btn_pulse = 4'b0000;
    bus.evt_ready = 1'b0;

    // Single pulse on button 0: pending, offered, accepted.
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Simultaneous pulses 1011 served 0,1,3.
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b1011, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b1010, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1010, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b1000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
    // Button 2 delivered, then 0 and 3 together: 3 first, then wrap to 0.
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0);
    add(1'b1, 4'b1001, 1'b1, 1'b0, 2'd2, 4'b1001, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 4'b0001, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0001, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
    // Reset mid-offer with pending 0110; dropped pulses raise overflow first.
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0111, 1'b0, 1'b0, 2'd0, 4'b0111, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0110, 1'b0);
    add(1'b1, 4'b0101, 1'b0, 1'b1, 2'd0, 4'b0110, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);
    add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
    add(1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].pulse, vecs[i].ready);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].id, vecs[i].pend, vecs[i].ovf);
    end

    // Stalled offer of button 1; repeat pulse on 1 overflows for one cycle.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    expect_out("stall_pend", 1'b0, 2'd0, 4'b0010, 1'b0);
    step(1'b1, 4'b0000, 1'b0);
    expect_out("stall_offer", 1'b1, 2'd1, 4'b0000, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      step(1'b1, (c == 4) ? 4'b0010 : 4'b0000, 1'b0);
      expect_out($sformatf("stall%0d", c), 1'b1, 2'd1, 4'b0000, (c == 4));
    end
    step(1'b1, 4'b0000, 1'b1);
    expect_out("stall_accept", 1'b0, 2'd1, 4'b0000, 1'b0);

    // Hold-off after delivering button 0: pulses at +5,+15,+16 ignored, +17 taken.
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    expect_out("hold_offer", 1'b1, 2'd0, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    expect_out("hold_accept", 1'b0, 2'd0, 4'b0000, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      step(1'b1, (k == 5 || k == 15 || k == 16 || k == 17) ? 4'b0001 : 4'b0000, 1'b1);
      if (k < 17)
        expect_out($sformatf("hold%0d", k), 1'b0, 2'd0, 4'b0000, 1'b0);
      else if (k == 17)
        expect_out("hold17", 1'b0, 2'd0, 4'b0001, 1'b0);
      else
        expect_out("hold18", 1'b1, 2'd0, 4'b0000, 1'b0);
    end
    step(1'b1, 4'b0000, 1'b1);
    expect_out("hold_done", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
